// File: rtl/gdi_logic_stage_if.sv
// Handshake bundle for gdi_logic_stage: operation request side and result side.
// slave is the stage's view; master is the upstream/downstream driver's view.
interface gdi_logic_stage_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_err;
  logic             out_zero;
  logic             out_par;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_err, out_zero, out_par
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_err, out_zero, out_par
  );
endinterface

// File: rtl/gdi_logic_stage.sv
// Registered valid/ready front end for the GDI logic gate bank (IDLE -> EVAL -> HOLD).
// Optional FLAGS_EN macro adds registered zero and parity flags on the result.
module gdi_logic_stage #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  gdi_logic_stage_if.slave bus,
  output logic [CNT_W-1:0] op_count_o
);

  typedef enum logic [1:0] {StIdle, StEval, StHold} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, res_sel;
  logic             err_q, err_d, err_sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] and_w, or_w, nand_w, nor_w, xor_w, xnor_w, inv_w;

  // One full gate set per bit; the opcode only picks which output is captured.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    andGdi  u_and  (.a_i(a_q[i]), .b_i(b_q[i]), .y_o(and_w[i]));
    orGdi   u_or   (.a_i(a_q[i]), .b_i(b_q[i]), .y_o(or_w[i]));
    nandGdi u_nand (.a_i(a_q[i]), .b_i(b_q[i]), .y_o(nand_w[i]));
    norGdi  u_nor  (.a_i(a_q[i]), .b_i(b_q[i]), .y_o(nor_w[i]));
    xorGdi  u_xor  (.a_i(a_q[i]), .b_i(b_q[i]), .y_o(xor_w[i]));
    xnorGdi u_xnor (.a_i(a_q[i]), .b_i(b_q[i]), .y_o(xnor_w[i]));
    invGdi  u_inv  (.a_i(a_q[i]), .y_o(inv_w[i]));
  end

  always_comb begin
    res_sel = '0;
    err_sel = 1'b0;
    case (op_q)
      3'b000:  res_sel = and_w;
      3'b001:  res_sel = or_w;
      3'b010:  res_sel = nand_w;
      3'b011:  res_sel = nor_w;
      3'b100:  res_sel = xor_w;
      3'b101:  res_sel = xnor_w;
      3'b110:  res_sel = inv_w;
      default: err_sel = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          op_d    = bus.in_op;
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          state_d = StEval;
        end
      end
      StEval: begin
        res_d   = res_sel;
        err_d   = err_sel;
        state_d = StHold;
      end
      StHold: begin
        if (bus.out_ready) begin
          state_d = StIdle;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FLAGS_EN
  logic zero_q, zero_d, par_q, par_d;

  always_comb begin
    zero_d = zero_q;
    par_d  = par_q;
    if (state_q == StEval) begin
      zero_d = (res_sel == '0);
      par_d  = ^res_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      par_q  <= par_d;
    end
  end

  assign bus.out_zero = zero_q;
  assign bus.out_par  = par_q;
`else
  assign bus.out_zero = 1'b0;
  assign bus.out_par  = 1'b0;
`endif

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StHold);
  assign bus.out_res   = res_q;
  assign bus.out_err   = err_q;
  assign op_count_o    = cnt_q;

endmodule

// GDI cell models: each is the basic G ? N : P cell with the sources tied per function.
module andGdi (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ? b_i : 1'b0;
endmodule

module orGdi (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ? 1'b1 : b_i;
endmodule

module nandGdi (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ? ~b_i : 1'b1;
endmodule

module norGdi (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ? 1'b0 : ~b_i;
endmodule

module xorGdi (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ? ~b_i : b_i;
endmodule

module xnorGdi (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);
  assign y_o = a_i ? b_i : ~b_i;
endmodule

module invGdi (
  input  logic a_i,
  output logic y_o
);
  assign y_o = a_i ? 1'b0 : 1'b1;
endmodule
